// File: rtl/instr_trace_buffer.sv
// Instruction trace buffer: snoops instruction-register loads into a ring.
// After an opcode trigger it takes a fixed number of further captures, then
// freezes. The frozen history drains oldest-first over a valid/ready port.
module instr_trace_buffer #(
    parameter int DEPTH = 16,
    parameter int PC_W  = 64,
    parameter int POST  = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            arm,
    input  logic            cap_valid,
    input  logic [31:0]     cap_instr,
    input  logic [PC_W-1:0] cap_pc,
    input  logic            trig_en,
    input  logic [6:0]      trig_opcode,
    input  logic [6:0]      trig_mask,
    input  logic            rd_ready,
    output logic            rd_valid,
    output logic [31:0]     rd_instr,
    output logic [PC_W-1:0] rd_pc,
    output logic            rd_trig,
    output logic [1:0]      state,
    output logic [CW-1:0]   count,
    output logic            overflow
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ARMED  = 2'd1,
        S_POST   = 2'd2,
        S_FROZEN = 2'd3
    } state_t;

    state_t cur_state;
    state_t nxt_state;

    logic [31:0]     mem_instr [DEPTH];
    logic [PC_W-1:0] mem_pc    [DEPTH];
    logic [DEPTH-1:0] trig_q;

    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic [CW-1:0] post_cnt;

    logic hit;
    logic capture;
    logic pop;

    // Read port handshake: an entry transfers on a rising edge where rd_valid
    // and rd_ready are both high. rd_valid never depends on rd_ready, and the
    // head entry holds steady while rd_valid is high and rd_ready is low.

    // Opcode trigger: masked compare of the low seven instruction bits.
    assign hit = cap_valid && trig_en &&
                 (((cap_instr[6:0] ^ trig_opcode) & trig_mask) == 7'd0);

    // arm takes priority over a same-cycle capture or pop.
    assign capture  = cap_valid && !arm && (cur_state == S_ARMED || cur_state == S_POST);
    assign rd_valid = (cur_state == S_FROZEN) && (count != '0);
    assign pop      = rd_valid && rd_ready && !arm;

    assign state    = cur_state;
    assign rd_instr = rd_valid ? mem_instr[rp] : 32'd0;
    assign rd_pc    = rd_valid ? mem_pc[rp] : '0;
    assign rd_trig  = rd_valid && trig_q[rp];

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur_state <= S_IDLE;
        end else begin
            cur_state <= nxt_state;
        end
    end

    // Next-state logic: trigger, post-trigger countdown, drain to empty.
    always_comb begin
        nxt_state = cur_state;
        if (arm) begin
            nxt_state = S_ARMED;
        end else begin
            case (cur_state)
                S_ARMED: begin
                    if (capture && hit) begin
                        nxt_state = (POST == 0) ? S_FROZEN : S_POST;
                    end
                end
                S_POST: begin
                    if (capture && post_cnt == CW'(1)) begin
                        nxt_state = S_FROZEN;
                    end
                end
                S_FROZEN: begin
                    if (pop && count == CW'(1)) begin
                        nxt_state = S_IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    // Ring bookkeeping: pointers, occupancy, overflow, trigger flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wp       <= '0;
            rp       <= '0;
            count    <= '0;
            overflow <= 1'b0;
            post_cnt <= '0;
            trig_q   <= '0;
        end else if (arm) begin
            wp       <= '0;
            rp       <= '0;
            count    <= '0;
            overflow <= 1'b0;
            post_cnt <= '0;
            trig_q   <= '0;
        end else if (capture) begin
            // Only the capture that fires the trigger is flagged; POST-phase
            // captures are never flagged even if their opcode matches.
            trig_q[wp] <= (cur_state == S_ARMED) && hit;
            wp         <= wp + AW'(1);
            if (count == CW'(DEPTH)) begin
                // Full ring: drop the oldest entry to make room.
                rp       <= rp + AW'(1);
                overflow <= 1'b1;
            end else begin
                count <= count + CW'(1);
            end
            if (cur_state == S_ARMED && hit) begin
                post_cnt <= CW'(POST);
            end else if (cur_state == S_POST) begin
                post_cnt <= post_cnt - CW'(1);
            end
        end else if (pop) begin
            rp    <= rp + AW'(1);
            count <= count - CW'(1);
        end
    end

    // Entry storage; contents are only ever exposed through rd_valid.
    always_ff @(posedge clk) begin
        if (capture) begin
            mem_instr[wp] <= cap_instr;
            mem_pc[wp]    <= cap_pc;
        end
    end

endmodule

// File: tb/tb_instr_trace_buffer.sv
// Bench for instr_trace_buffer: directed table and sequences plus random
// traffic against a queue-based reference model of the trace ring.
module tb_instr_trace_buffer;

    localparam int DEPTH = 16;
    localparam int PC_W  = 64;
    localparam int POST  = 4;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int W     = 1 + PC_W + 32;

    logic            clk = 1'b0;
    logic            reset;
    logic            arm, arm0;
    logic            cap_valid;
    logic [31:0]     cap_instr;
    logic [PC_W-1:0] cap_pc;
    logic            trig_en;
    logic [6:0]      trig_opcode;
    logic [6:0]      trig_mask;
    logic            rd_ready, rd_ready0;

    logic            rd_valid, rd_valid0;
    logic [31:0]     rd_instr, rd_instr0;
    logic [PC_W-1:0] rd_pc, rd_pc0;
    logic            rd_trig, rd_trig0;
    logic [1:0]      state, state0;
    logic [CW-1:0]   count, count0;
    logic            overflow, overflow0;

    instr_trace_buffer #(.DEPTH(DEPTH), .PC_W(PC_W), .POST(POST)) u_dut (
        .clk(clk), .reset(reset), .arm(arm), .cap_valid(cap_valid),
        .cap_instr(cap_instr), .cap_pc(cap_pc), .trig_en(trig_en),
        .trig_opcode(trig_opcode), .trig_mask(trig_mask), .rd_ready(rd_ready),
        .rd_valid(rd_valid), .rd_instr(rd_instr), .rd_pc(rd_pc), .rd_trig(rd_trig),
        .state(state), .count(count), .overflow(overflow)
    );

    instr_trace_buffer #(.DEPTH(DEPTH), .PC_W(PC_W), .POST(0)) u_dut0 (
        .clk(clk), .reset(reset), .arm(arm0), .cap_valid(cap_valid),
        .cap_instr(cap_instr), .cap_pc(cap_pc), .trig_en(trig_en),
        .trig_opcode(trig_opcode), .trig_mask(trig_mask), .rd_ready(rd_ready0),
        .rd_valid(rd_valid0), .rd_instr(rd_instr0), .rd_pc(rd_pc0), .rd_trig(rd_trig0),
        .state(state0), .count(count0), .overflow(overflow0)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard / reference model ----------------
    // exp_q holds the ring contents oldest-first as {trig, pc, instr}.
    logic [W-1:0] exp_q[$];
    int m_state;
    bit m_ovf;
    int m_left;
    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_state = 0;
        m_ovf   = 1'b0;
        m_left  = 0;
    endtask

    task automatic check_main();
        logic [W-1:0] head;
        bit v;
        v    = (m_state == 3) && (exp_q.size() > 0);
        head = v ? exp_q[0] : '0;
        chk("state",    64'(state),    64'(m_state));
        chk("count",    64'(count),    64'(exp_q.size()));
        chk("overflow", 64'(overflow), 64'(m_ovf));
        chk("rd_valid", 64'(rd_valid), 64'(v));
        chk("rd_instr", 64'(rd_instr), 64'(head[31:0]));
        chk("rd_pc",    rd_pc,         head[PC_W+31:32]);
        chk("rd_trig",  64'(rd_trig),  64'(head[W-1]));
    endtask

    // One clock: model consumes the inputs present before the edge, then
    // the main DUT is compared just after the edge.
    task automatic cycle();
        bit m;
        m = cap_valid && trig_en && (((cap_instr[6:0] ^ trig_opcode) & trig_mask) == 7'd0);
        if (arm) begin
            model_reset();
            m_state = 1;
        end else if ((m_state == 1 || m_state == 2) && cap_valid) begin
            exp_q.push_back({(m_state == 1) && m, cap_pc, cap_instr});
            if (exp_q.size() > DEPTH) begin
                void'(exp_q.pop_front());
                m_ovf = 1'b1;
            end
            if (m_state == 1 && m) begin
                if (POST == 0) m_state = 3;
                else begin
                    m_state = 2;
                    m_left  = POST;
                end
            end else if (m_state == 2) begin
                m_left--;
                if (m_left == 0) m_state = 3;
            end
        end else if (m_state == 3 && exp_q.size() > 0 && rd_ready) begin
            void'(exp_q.pop_front());
            if (exp_q.size() == 0) m_state = 0;
        end
        @(posedge clk);
        #1;
        check_main();
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        arm = 1'b0; arm0 = 1'b0; cap_valid = 1'b0;
        rd_ready = 1'b0; rd_ready0 = 1'b0;
    endtask

    task automatic do_arm();
        arm = 1'b1;
        cycle();
        arm = 1'b0;
    endtask

    task automatic cap(input logic [31:0] instr, input logic [63:0] pc);
        cap_valid = 1'b1;
        cap_instr = instr;
        cap_pc    = pc;
        cycle();
        cap_valid = 1'b0;
    endtask

    task automatic drain(input bit stall_pattern);
        for (int k = 0; k < 100 && exp_q.size() > 0; k++) begin
            rd_ready = stall_pattern ? ((k % 4) == 0 || (k % 4) == 3) : 1'b1;
            cycle();
        end
        rd_ready = 1'b0;
        chk("drain_idle", 64'(state), 64'd0);
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [31:0]     instr;
        logic [PC_W-1:0] pc;
        logic [1:0]      exp_state;
        logic [CW-1:0]   exp_count;
    } vec_t;
    vec_t vecs[8];

    initial begin
        idle_inputs();
        cap_instr = '0; cap_pc = '0;
        trig_en = 1'b0; trig_opcode = 7'd0; trig_mask = 7'd0;
        reset = 1'b0;
        model_reset();

        // Reset values while reset is held.
        repeat (2) @(posedge clk);
        #1;
        check_main();
        chk("rst_state0", 64'(state0), 64'd0);
        chk("rst_valid0", 64'(rd_valid0), 64'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_main();

        // Basic trigger: store opcode on the 4th capture, POST = 4.
        trig_en = 1'b1; trig_opcode = 7'h23; trig_mask = 7'h7F;
        for (int i = 0; i < 8; i++) begin
            vecs[i].instr     = {25'(i + 1), (i == 3) ? 7'h23 : 7'h13};
            vecs[i].pc        = 64'h1000 + 64'(4 * i);
            vecs[i].exp_state = (i < 3) ? 2'd1 : (i < 7) ? 2'd2 : 2'd3;
            vecs[i].exp_count = CW'(i + 1);
        end
        do_arm();
        for (int i = 0; i < 8; i++) begin
            cap(vecs[i].instr, vecs[i].pc);
            chk("tbl_state", 64'(state), 64'(vecs[i].exp_state));
            chk("tbl_count", 64'(count), 64'(vecs[i].exp_count));
        end
        chk("tbl_overflow", 64'(overflow), 64'd0);
        rd_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("tbl_rd_valid", 64'(rd_valid), 64'd1);
            chk("tbl_rd_pc",    rd_pc,         vecs[i].pc);
            chk("tbl_rd_instr", 64'(rd_instr), 64'(vecs[i].instr));
            chk("tbl_rd_trig",  64'(rd_trig),  64'(i == 3));
            cycle();
        end
        rd_ready = 1'b0;
        chk("tbl_idle", 64'(state), 64'd0);

        // Wrap: 20 plain captures, trigger, 4 post captures -> 25 total.
        do_arm();
        for (int i = 1; i <= 20; i++) cap({25'(i), 7'h13}, 64'h2000 + 64'(8 * i));
        cap({25'd21, 7'h23}, 64'h2000 + 64'(8 * 21));
        for (int i = 22; i <= 25; i++) cap({25'(i), 7'h13}, 64'h2000 + 64'(8 * i));
        chk("wrap_state",    64'(state),    64'd3);
        chk("wrap_count",    64'(count),    64'd16);
        chk("wrap_overflow", 64'(overflow), 64'd1);
        chk("wrap_first_pc", rd_pc,         64'h2000 + 64'(8 * 10));
        drain(1'b0);

        // Arm collides with a capture while frozen with 5 entries.
        do_arm();
        cap({25'd1, 7'h23}, 64'h3000);
        for (int i = 1; i <= 4; i++) cap({25'(i + 1), 7'h13}, 64'h3000 + 64'(4 * i));
        chk("coll_pre_state", 64'(state), 64'd3);
        chk("coll_pre_count", 64'(count), 64'd5);
        arm = 1'b1; cap_valid = 1'b1; cap_instr = {25'd99, 7'h23}; cap_pc = 64'hDEAD;
        cycle();
        arm = 1'b0; cap_valid = 1'b0;
        chk("coll_state",    64'(state),    64'd1);
        chk("coll_count",    64'(count),    64'd0);
        chk("coll_overflow", 64'(overflow), 64'd0);
        cap({25'd7, 7'h23}, 64'h3100);
        for (int i = 1; i <= 4; i++) cap({25'(i + 7), 7'h13}, 64'h3100 + 64'(4 * i));
        chk("coll_head_pc", rd_pc, 64'h3100);

        // Backpressure: rd_ready pattern 1,0,0,1 while draining.
        drain(1'b1);

        // POST = 0 instance with masked compare on the low 4 opcode bits.
        trig_mask = 7'h0F;
        arm0 = 1'b1;
        cycle();
        arm0 = 1'b0;
        begin
            logic [6:0] ops [4];
            ops[0] = 7'h37; ops[1] = 7'h6F; ops[2] = 7'h17; ops[3] = 7'h33;
            for (int i = 0; i < 4; i++) begin
                cap({25'(i + 40), ops[i]}, 64'h4000 + 64'(4 * i));
                chk("p0_state", 64'(state0), (i < 3) ? 64'd1 : 64'd3);
                chk("p0_count", 64'(count0), 64'(i + 1));
            end
            rd_ready0 = 1'b1;
            for (int i = 0; i < 4; i++) begin
                chk("p0_rd_valid", 64'(rd_valid0), 64'd1);
                chk("p0_rd_pc",    rd_pc0,         64'h4000 + 64'(4 * i));
                chk("p0_rd_trig",  64'(rd_trig0),  64'(i == 3));
                cycle();
            end
            rd_ready0 = 1'b0;
            chk("p0_idle",  64'(state0),    64'd0);
            chk("p0_valid", 64'(rd_valid0), 64'd0);
        end

        // Async reset between edges while in POST.
        trig_mask = 7'h7F;
        do_arm();
        cap({25'd1, 7'h23}, 64'h5000);
        cap({25'd2, 7'h13}, 64'h5004);
        chk("ar_pre_state", 64'(state), 64'd2);
        #2;
        reset = 1'b0;
        #1;
        chk("ar_state",    64'(state),    64'd0);
        chk("ar_count",    64'(count),    64'd0);
        chk("ar_rd_valid", 64'(rd_valid), 64'd0);
        model_reset();
        @(posedge clk);
        #2;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_main();
        cap({25'd3, 7'h23}, 64'h5100);
        cap({25'd4, 7'h13}, 64'h5104);
        chk("ar_ignored", 64'(count), 64'd0);

        // Random traffic against the reference model.
        do_arm();
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] ins;
            ins = $urandom();
            if ($urandom_range(0, 3) == 0) ins[6:0] = 7'h23;
            arm       = ($urandom_range(0, 40) == 0);
            cap_valid = $urandom_range(0, 1) == 1;
            cap_instr = ins;
            cap_pc    = {$urandom(), $urandom()};
            trig_en   = ($urandom_range(0, 7) != 0);
            case ($urandom_range(0, 2))
                0: trig_mask = 7'h7F;
                1: trig_mask = 7'h0F;
                default: trig_mask = 7'h70;
            endcase
            rd_ready = $urandom_range(0, 1) == 1;
            cycle();
        end
        idle_inputs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
